ring_phase_monitor: RTL

//   Consumer stage for the one-hot ring counter. Samples the N-bit ring state and

---
 rtl/ring_phase_monitor.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ring_phase_monitor.sv
// rtl/ring_phase_monitor.sv - one-hot ring phase checker, phase encoder and revolution counter
//
// Samples an N-bit one-hot ring state. It checks that the hot bit advances one
// position per enabled sample, and reports the binary phase of the hot bit.
// It counts completed revolutions. Persistent corruption while locked raises a
// fault and a one-cycle resync request.
//
// Ports:
//   clk         in   rising-edge clock, shared with the ring counter
//   reset       in   synchronous active-low reset
//   en          in   sample/evaluate enable, 0 holds all state
//   ring_q      in   [N-1:0] ring counter state
//   fault_clr   in   leave FAULT and return to HUNT
//   phase       out  [PW-1:0] binary index of the hot bit
//   phase_valid out  phase is valid this cycle
//   rev_tick    out  one-cycle pulse per completed revolution
//   rev_count   out  [REV_W-1:0] wrapping revolution count
//   locked      out  monitor is LOCKED
//   fault       out  monitor is in FAULT
//   resync_req  out  one-cycle pulse on entry to FAULT
module ring_phase_monitor #(
    parameter int N         = 4,
    parameter int REV_W     = 8,
    parameter int LOCK_CNT  = 4,
    parameter int ERR_LIMIT = 2,
    localparam int PW       = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [N-1:0]     ring_q,
    input  logic             fault_clr,
    output logic [PW-1:0]    phase,
    output logic             phase_valid,
    output logic             rev_tick,
    output logic [REV_W-1:0] rev_count,
    output logic             locked,
    output logic             fault,
    output logic             resync_req
);

    localparam int CW = $clog2(N + 1);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(ERR_LIMIT + 1);

    // The counters never exceed LIMIT-1 before a transition, so comparing
    // against LIMIT-1 avoids widening the increment.
    localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_CNT - 1);
    localparam logic [MW-1:0] ERR_LAST  = MW'(ERR_LIMIT - 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      s_q, s_d;
    logic [N-1:0]      exp_q, exp_d;
    logic [GW-1:0]     good_q, good_d;
    logic [MW-1:0]     miss_q, miss_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic              pv_q, pv_d;
    logic              rt_q, rt_d;
    logic [REV_W-1:0]  rev_q, rev_d;
    logic              locked_q, locked_d;
    logic              fault_q, fault_d;
    logic              rr_q, rr_d;

    logic [CW-1:0]     ones;
    logic              oh;
    logic              match;
    logic [PW-1:0]     hot_idx;

    function automatic logic [N-1:0] rotl(input logic [N-1:0] x);
        return {x[N-2:0], x[N-1]};
    endfunction

    // Population count and hot-bit index of the sampled ring value.
    always_comb begin
        ones    = '0;
        hot_idx = '0;
        for (int i = 0; i < N; i++) begin
            ones = ones + CW'(s_q[i]);
            if (s_q[i]) begin
                hot_idx = PW'(i);
            end
        end
    end

    assign oh    = (ones == CW'(1));
    assign match = oh && (s_q == exp_q);

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        exp_d   = exp_q;
        good_d  = good_q;
        miss_d  = miss_q;
        phase_d = phase_q;
        pv_d    = pv_q;
        rt_d    = 1'b0;
        rev_d   = rev_q;
        rr_d    = 1'b0;

        if (en) begin
            s_d  = ring_q;
            pv_d = 1'b0;
            unique case (state_q)
                ST_HUNT: begin
                    exp_d = oh ? rotl(s_q) : '0;
                    if (match) begin
                        if (good_q == LOCK_LAST) begin
                            state_d = ST_LOCKED;
                            good_d  = '0;
                            miss_d  = '0;
                        end else begin
                            good_d = good_q + GW'(1);
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (match) begin
                        pv_d    = 1'b1;
                        phase_d = hot_idx;
                        rt_d    = s_q[0];
                        miss_d  = '0;
                        exp_d   = rotl(s_q);
                    end else begin
                        // Flywheel: keep predicting so a single glitch does not lose phase.
                        exp_d = rotl(exp_q);
                        if (miss_q == ERR_LAST) begin
                            state_d = ST_FAULT;
                            rr_d    = 1'b1;
                        end else begin
                            miss_d = miss_q + MW'(1);
                        end
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        state_d = ST_HUNT;
                        good_d  = '0;
                        miss_d  = '0;
                        exp_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
            rev_d = rev_q + REV_W'(rt_d);
        end

        locked_d = (state_d == ST_LOCKED);
        fault_d  = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_HUNT;
            s_q      <= '0;
            exp_q    <= '0;
            good_q   <= '0;
            miss_q   <= '0;
            phase_q  <= '0;
            pv_q     <= 1'b0;
            rt_q     <= 1'b0;
            rev_q    <= '0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
            rr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            exp_q    <= exp_d;
            good_q   <= good_d;
            miss_q   <= miss_d;
            phase_q  <= phase_d;
            pv_q     <= pv_d;
            rt_q     <= rt_d;
            rev_q    <= rev_d;
            locked_q <= locked_d;
            fault_q  <= fault_d;
            rr_q     <= rr_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = pv_q;
    assign rev_tick    = rt_q;
    assign rev_count   = rev_q;
    assign locked      = locked_q;
    assign fault       = fault_q;
    assign resync_req  = rr_q;

endmodule
